// File: rtl/peso_alvo.sv
// ============================================================================
//  Module   : peso_alvo
//  Purpose  : Target weight for pre-pay mode: weight_kg = total_price / price_per_kg,
//             restoring divider producing one quotient bit per clock.
//  Option   : PESO_ALVO_ROUND_EN rounds the quotient to nearest (saturating).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module peso_alvo #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] total_price,
    input  logic [WIDTH-1:0] price_per_kg,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] weight_kg,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic [WIDTH:0]   w_partial;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quot_next;
    logic [WIDTH-1:0] w_result;

    // Quotient bits shift into the dividend register from the LSB side as the
    // dividend bits leave from the MSB side, so after WIDTH steps it holds the quotient.
    assign w_accept    = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_partial   = {r_rem, r_dividend[WIDTH-1]};
    assign w_ge        = (w_partial >= {1'b0, r_divisor});
    assign w_diff      = w_partial[WIDTH-1:0] - r_divisor;
    assign w_rem_next  = w_ge ? w_diff : w_partial[WIDTH-1:0];
    assign w_quot_next = {r_dividend[WIDTH-2:0], w_ge};

`ifdef PESO_ALVO_ROUND_EN
    logic w_round_up;
    assign w_round_up = ({w_rem_next, 1'b0} >= {1'b0, r_divisor});
    assign w_result   = (w_round_up && !(&w_quot_next)) ? w_quot_next + 1'b1 : w_quot_next;
`else
    assign w_result   = w_quot_next;
`endif

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done = (r_state == S_DONE);
                if (start) begin
                    w_state_next = (price_per_kg == '0) ? S_DONE : S_CALC;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            weight_kg   <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_dividend  <= total_price;
                r_divisor   <= price_per_kg;
                r_rem       <= '0;
                r_cnt       <= CNT_W'(WIDTH - 1);
                div_by_zero <= (price_per_kg == '0);
                if (price_per_kg == '0) begin
                    weight_kg <= '1;
                    remainder <= total_price;
                end
            end else if (r_state == S_CALC) begin
                r_dividend <= w_quot_next;
                r_rem      <= w_rem_next;
                r_cnt      <= r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    weight_kg <= w_result;
                    remainder <= w_rem_next;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_peso_alvo.sv
// Bench for peso_alvo: directed table, randomized ops against an arithmetic
// model, and hand-written sequences for handshake, back-to-back and reset cases.
`default_nettype none

module tb_peso_alvo;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] total_price;
    logic [15:0] price_per_kg;
    logic        busy;
    logic        done;
    logic [15:0] weight_kg;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;
    int n_done_pulses = 0;

    always #5 clk = ~clk;

    peso_alvo #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .total_price  (total_price),
        .price_per_kg (price_per_kg),
        .busy         (busy),
        .done         (done),
        .weight_kg    (weight_kg),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero)
    );

    always @(negedge clk) if (done === 1'b1) n_done_pulses++;

    typedef struct {
        logic [15:0] t;
        logic [15:0] p;
        logic [15:0] w;
        logic [15:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division, rounding to nearest when enabled.
    function automatic void model(input int t, input int p, output int w, output int r, output int dbz);
        if (p == 0) begin
            w = 65535; r = t; dbz = 1;
        end else begin
            w = t / p; r = t % p; dbz = 0;
`ifdef PESO_ALVO_ROUND_EN
            if (2 * r >= p && w < 65535) w = w + 1;
`endif
        end
    endfunction

    task automatic run_op(input logic [15:0] t, input logic [15:0] p, output int lat);
        @(negedge clk);
        total_price = t; price_per_kg = p; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op_expect(input string tag, input logic [15:0] t, input logic [15:0] p,
                             input int ew, input int er, input int edbz, input int elat);
        int lat;
        run_op(t, p, lat);
        check({tag, "_latency"}, lat, elat);
        check({tag, "_weight"}, weight_kg, ew);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_dbz"}, div_by_zero, edbz);
        check({tag, "_busy_in_done"}, busy, 0);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        vec_t vecs[7];
        int ew, er, edbz, lat, p0, first, second;
        logic [15:0] t, p;

        vecs[0] = '{16'd10000, 16'd20,    16'd500,   16'd0,     1'b0, 17};
`ifdef PESO_ALVO_ROUND_EN
        vecs[1] = '{16'd10015, 16'd20,    16'd501,   16'd15,    1'b0, 17};
        vecs[6] = '{16'd65535, 16'd32768, 16'd2,     16'd32767, 1'b0, 17};
`else
        vecs[1] = '{16'd10015, 16'd20,    16'd500,   16'd15,    1'b0, 17};
        vecs[6] = '{16'd65535, 16'd32768, 16'd1,     16'd32767, 1'b0, 17};
`endif
        vecs[2] = '{16'd10007, 16'd20,    16'd500,   16'd7,     1'b0, 17};
        vecs[3] = '{16'd1234,  16'd0,     16'hFFFF,  16'd1234,  1'b1, 1};
        vecs[4] = '{16'd5,     16'd20,    16'd0,     16'd5,     1'b0, 17};
        vecs[5] = '{16'd65535, 16'd1,     16'd65535, 16'd0,     1'b0, 17};

        rst = 1'b1; start = 1'b0; total_price = '0; price_per_kg = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_weight", weight_kg, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", div_by_zero, 0);

        for (int i = 0; i < 7; i++) begin
            op_expect($sformatf("vec%0d", i), vecs[i].t, vecs[i].p,
                      vecs[i].w, vecs[i].r, vecs[i].dbz, vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            t = 16'($urandom);
            case ($urandom_range(0, 3))
                0: p = 16'($urandom_range(1, 15));
                1: p = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
                2: p = 16'($urandom);
                default: p = t >> $urandom_range(0, 15);
            endcase
            model(t, p, ew, er, edbz);
            op_expect($sformatf("rnd%0d", i), t, p, ew, er, edbz, (p == 0) ? 1 : 17);
        end

        // Restart attempts and operand changes during CALC must be ignored.
        p0 = n_done_pulses; first = 0;
        @(negedge clk);
        total_price = 16'd1000; price_per_kg = 16'd7; start = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (e == 1) start = 1'b0;
            if (e == 4) begin start = 1'b1; total_price = 16'd555; price_per_kg = 16'd3; end
            if (e == 12) start = 1'b0;
            if (done === 1'b1 && first == 0) first = e;
        end
        model(1000, 7, ew, er, edbz);
        check("ignore_latency", first, 17);
        check("ignore_done_count", n_done_pulses - p0, 1);
        check("ignore_weight", weight_kg, ew);
        check("ignore_remainder", remainder, er);

        // Start held high through DONE chains straight into the next operation.
        first = 0; second = 0;
        @(negedge clk);
        total_price = 16'd300; price_per_kg = 16'd7; start = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (e == 1) begin total_price = 16'd4000; price_per_kg = 16'd9; end
            if (done === 1'b1) begin
                if (first == 0) begin
                    first = e;
                    model(300, 7, ew, er, edbz);
                    check("b2b_first_weight", weight_kg, ew);
                    check("b2b_first_remainder", remainder, er);
                end else if (second == 0) begin
                    second = e;
                end
            end
            if (e == 18) start = 1'b0;
        end
        model(4000, 9, ew, er, edbz);
        check("b2b_first_latency", first, 17);
        check("b2b_second_latency", second, 34);
        check("b2b_second_weight", weight_kg, ew);
        check("b2b_second_remainder", remainder, er);

        // Reset in the middle of a calculation aborts without a done pulse.
        op_expect("pre_rst_dbz", 16'd777, 16'd0, 65535, 777, 1, 1);
        @(negedge clk);
        total_price = 16'd50000; price_per_kg = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        p0 = n_done_pulses;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_weight", weight_kg, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_dbz", div_by_zero, 0);
        repeat (20) @(posedge clk);
        check("midrst_no_done", n_done_pulses - p0, 0);
        model(50000, 3, ew, er, edbz);
        op_expect("post_rst", 16'd50000, 16'd3, ew, er, edbz, 17);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
